fixed_divider: RTL and testbench

Sequential signed fixed-point divider: `out = i_A / i_B` in the same QN-Q.Q format (default Q8.8) as the FFT datapath multiplier, i.e. the inverse operation of that multiplier. Operands are latched on a start strobe. A restoring shift-subtract loop produces one quotient bit per clock. The result is sign-corrected, saturated, and announced with a one-cycle done pulse. It sits beside the multiplier in the FFT datapath for normalisation and scaling stages.

---
 rtl/fixed_divider.sv | 132 +++++++++++++
 tb/tb_fixed_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fixed_divider.sv
// Signed Q-format divider out = i_A / i_B with a restoring loop that produces one quotient bit per clock.
// Latency: done pulses N+Q+1 edges after the start edge; one result every N+Q+2 cycles, back-to-back capable.
// Backpressure: none. i_start is sampled only in IDLE, and a start while busy is dropped, not queued.
module fixed_divider #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    output logic [N-1:0] out,
    output logic         o_div_done,
    output logic         o_busy,
    output logic         o_div_by_zero
);

    localparam int CW = $clog2(N + Q + 1);

    localparam logic [N+Q-1:0] POS_LIM = (N+Q)'((1 << (N - 1)) - 1);
    localparam logic [N+Q-1:0] NEG_LIM = (N+Q)'(1 << (N - 1));
    localparam logic [N-1:0]   SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]   SAT_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIN
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic           neg_q;
    logic           a_neg_q;
    logic           b_zero_q;
    logic [N-1:0]   b_mag_q;
    logic [N+Q-1:0] dvd_q;
    logic [N:0]     rem_q;
    logic [N+Q-1:0] quo_q;
    logic [CW-1:0]  cnt_q;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N:0]     rem_shift;
    logic [N-1:0]   res;

    // Two's-complement magnitude; 0x8000 maps to 32768 as an unsigned N-bit value.
    assign a_mag     = i_A[N-1] ? (~i_A + N'(1)) : i_A;
    assign b_mag     = i_B[N-1] ? (~i_B + N'(1)) : i_B;
    assign rem_shift = {rem_q[N-1:0], dvd_q[N+Q-1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_DIV;
            S_DIV:   if (cnt_q == CW'(1)) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            b_mag_q  <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == S_IDLE && i_start) begin
            neg_q    <= i_A[N-1] ^ i_B[N-1];
            a_neg_q  <= i_A[N-1];
            b_zero_q <= (i_B == '0);
            b_mag_q  <= b_mag;
            dvd_q    <= {a_mag, {Q{1'b0}}};
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= CW'(N + Q);
        end else if (state_q == S_DIV) begin
            dvd_q <= dvd_q << 1;
            cnt_q <= cnt_q - CW'(1);
            if (rem_shift >= {1'b0, b_mag_q}) begin
                rem_q <= rem_shift - {1'b0, b_mag_q};
                quo_q <= {quo_q[N+Q-2:0], 1'b1};
            end else begin
                rem_q <= rem_shift;
                quo_q <= {quo_q[N+Q-2:0], 1'b0};
            end
        end
    end

    // A zero magnitude negates to zero, so a zero dividend never yields negative zero.
    always_comb begin
        res = quo_q[N-1:0];
        if (b_zero_q) begin
            res = a_neg_q ? SAT_NEG : SAT_POS;
        end else if (!neg_q) begin
            res = (quo_q > POS_LIM) ? SAT_POS : quo_q[N-1:0];
        end else begin
            res = (quo_q > NEG_LIM) ? SAT_NEG : (~quo_q[N-1:0] + N'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out           <= '0;
            o_div_done    <= 1'b0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_div_done <= (state_q == S_FIN);
            if (state_q == S_FIN) begin
                out           <= res;
                o_div_by_zero <= b_zero_q;
            end
        end
    end

    assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_fixed_divider.sv
// Directed-vector bench for fixed_divider (Q8.8): values, sign/saturation/zero cases, latency and protocol.
module tb_fixed_divider;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [15:0] i_A;
    logic [15:0] i_B;
    logic [15:0] out;
    logic        o_div_done;
    logic        o_busy;
    logic        o_div_by_zero;

    int total = 0;
    int bad   = 0;

    fixed_divider #(.N(16), .Q(8)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_A           (i_A),
        .i_B           (i_B),
        .out           (out),
        .o_div_done    (o_div_done),
        .o_busy        (o_busy),
        .o_div_by_zero (o_div_by_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One operation: start on a negedge, scramble operands after the start edge,
    // then watch latency, busy width and that out holds its old value until done.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_q, input logic exp_z,
                         input string tag, input bit mid_start);
        int          n;
        int          busy_n;
        bit          held;
        logic [15:0] prev;
        @(negedge i_clk);
        i_A     = a;
        i_B     = b;
        i_start = 1'b1;
        prev    = out;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_A     = 16'h7FFF;
        i_B     = 16'h0000;
        busy_n  = o_busy ? 1 : 0;
        held    = 1'b1;
        n       = 0;
        while (n < 100 && !o_div_done) begin
            if (mid_start && n == 5) begin
                i_A = 16'h0100;
                i_B = 16'h0100;
            end
            i_start = (mid_start && n == 5);
            @(posedge i_clk);
            #1;
            n++;
            if (!o_div_done) begin
                if (o_busy) busy_n++;
                if (out !== prev) held = 1'b0;
            end
        end
        i_start = 1'b0;
        check({tag, "_lat"},  n, 25);
        check({tag, "_busy"}, busy_n, 25);
        check({tag, "_hold"}, held, 1);
        check({tag, "_out"},  out, exp_q);
        check({tag, "_dbz"},  o_div_by_zero, exp_z);
        check({tag, "_idle"}, o_busy, 0);
    endtask

    initial begin
        int n;
        int dones;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_A     = '0;
        i_B     = '0;
        #3;
        check("rst_out",  out, 0);
        check("rst_done", o_div_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_dbz",  o_div_by_zero, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        do_op(16'h0100, 16'h0300, 16'h0055, 1'b0, "one_third", 1'b0);
        @(posedge i_clk);
        #1;
        check("done_fall", o_div_done, 0);

        do_op(16'hFF00, 16'h0300, 16'hFFAB, 1'b0, "neg_third", 1'b0);
        do_op(16'h0280, 16'hFF80, 16'hFB00, 1'b0, "pos_negb",  1'b0);
        do_op(16'hFD80, 16'hFF80, 16'h0500, 1'b0, "neg_neg",   1'b0);
        do_op(16'h8000, 16'h0100, 16'h8000, 1'b0, "min_one",   1'b0);
        do_op(16'h6400, 16'h0080, 16'h7FFF, 1'b0, "sat_pos",   1'b0);
        do_op(16'h9C00, 16'h0080, 16'h8000, 1'b0, "sat_neg",   1'b0);
        do_op(16'h0300, 16'h0000, 16'h7FFF, 1'b1, "dz_pos",    1'b0);
        do_op(16'hFD00, 16'h0000, 16'h8000, 1'b1, "dz_neg",    1'b0);
        do_op(16'h0100, 16'h0100, 16'h0100, 1'b0, "dz_clear",  1'b0);
        do_op(16'h0000, 16'hFF00, 16'h0000, 1'b0, "zero_div",  1'b0);

        // A start while busy must be dropped, not queued.
        do_op(16'h0280, 16'hFF80, 16'hFB00, 1'b0, "mid_start", 1'b1);
        dones = 0;
        repeat (30) begin
            @(posedge i_clk);
            #1;
            if (o_div_done) dones++;
        end
        check("mid_noqueue", dones, 0);

        // Back-to-back: start held during the done cycle.
        do_op(16'hFD80, 16'hFF80, 16'h0500, 1'b0, "b2b_first", 1'b0);
        i_A     = 16'h0100;
        i_B     = 16'h0300;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        n = 1;
        while (n < 100 && !o_div_done) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("b2b_lat", n, 26);
        check("b2b_out", out, 16'h0055);

        // Asynchronous reset in the middle of an operation.
        @(negedge i_clk);
        i_A     = 16'h0100;
        i_B     = 16'h0300;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (10) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_out",  out, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_div_done, 0);
        check("arst_dbz",  o_div_by_zero, 0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        dones = 0;
        repeat (30) begin
            @(posedge i_clk);
            #1;
            if (o_div_done) dones++;
        end
        check("arst_nodone", dones, 0);
        do_op(16'h0200, 16'h0100, 16'h0200, 1'b0, "post_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
